// File: rtl/ps2_pkg.sv
// Purpose : shared constants and types for the PS/2 receive scanner.
// Latency : n/a (package only).
// Backpressure: n/a; contents are frame constants, the bit-counter type and a parity helper.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;

  // Bit index within a frame: 0 = start, 1..8 = data, 9 = parity, 10 = stop.
  typedef logic [3:0] bitcnt_t;

  localparam bitcnt_t PS2_PAR_IDX  = bitcnt_t'(PS2_FRAME_BITS - 2);
  localparam bitcnt_t PS2_STOP_IDX = bitcnt_t'(PS2_FRAME_BITS - 1);

  // True when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity(input logic [8:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ps2_rx_scanner_if.sv
// Purpose : groups the PS/2 pins and the decoded key outputs of the scanner.
// Latency : n/a (wiring only).
// Backpressure: none; byte_valid is a one-cycle strobe with no ready.
// Ports   : ps2_clk/ps2_data raw pins; ps2_byte make code, ps2_state held flag,
//           ps2_ext E0-prefixed flag, byte_valid new-make strobe.
//           master = pin driver / result consumer, slave = the scanner.
interface ps2_rx_scanner_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] ps2_byte;
  logic       ps2_state;
  logic       ps2_ext;
  logic       byte_valid;

  modport master (
    output ps2_clk, ps2_data,
    input  ps2_byte, ps2_state, ps2_ext, byte_valid
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output ps2_byte, ps2_state, ps2_ext, byte_valid
  );
endinterface

// File: rtl/ps2_sync_edge.sv
// Purpose : synchronizes the raw PS/2 pins into clk and flags ps2_clk falling edges.
// Latency : data_s / clk_fall valid SYNC_STAGES clks after the pin changes.
// Backpressure: none; free-running sampler.
// Ports   : clk, rst_n; ps2_clk, ps2_data raw async pins;
//           data_s synchronized data, clk_fall one-cycle pulse per falling ps2_clk.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_s,
  output logic clk_fall
);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;

  // Reset to the idle-high bus level so release of reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign data_s   = r_data_sync[SYNC_STAGES-1];
  assign clk_fall = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_rx_scanner.sv
// Purpose : PS/2 keyboard receiver; deframes 11-bit frames, tracks E0/F0 prefixes, reports make codes.
// Latency : byte_valid rises SYNC_STAGES+1 clks after the raw falling ps2_clk of the stop bit.
// Backpressure: none; byte_valid is a one-cycle strobe, consumer must take it when seen.
// Ports   : clk, rst_n (async active-low); bus (slave modport) carries the pins and
//           ps2_byte / ps2_state / ps2_ext / byte_valid.
// Config  : define PS2_PARITY_CHECK_EN to drop frames with even parity; otherwise the
//           parity bit is ignored and only start/stop bits gate acceptance.
module ps2_rx_scanner
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  ps2_rx_scanner_if.slave   bus
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic            w_data_s;
  logic            w_clk_fall;
  logic            w_frame_ok;

  bitcnt_t         r_bit_cnt;
  logic [7:0]      r_data;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_ext_pend;
  logic            r_brk_pend;
  logic [7:0]      r_byte;
  logic            r_state;
  logic            r_ext;
  logic            r_valid;
`ifdef PS2_PARITY_CHECK_EN
  logic            r_par;
`endif

  ps2_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (bus.ps2_clk),
    .ps2_data (bus.ps2_data),
    .data_s   (w_data_s),
    .clk_fall (w_clk_fall)
  );

  // Evaluated on the stop-bit edge: w_data_s is the stop bit itself.
`ifdef PS2_PARITY_CHECK_EN
  assign w_frame_ok = w_data_s & odd_parity({r_par, r_data});
`else
  assign w_frame_ok = w_data_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt  <= '0;
      r_data     <= '0;
      r_to_cnt   <= '0;
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
      r_byte     <= 8'h00;
      r_state    <= 1'b0;
      r_ext      <= 1'b0;
      r_valid    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      if (w_clk_fall) begin
        r_to_cnt <= '0;
        if (r_bit_cnt == '0) begin
          // A high start bit is line noise: stay idle and wait for a real start.
          if (!w_data_s) r_bit_cnt <= 4'd1;
        end else if (r_bit_cnt == PS2_STOP_IDX) begin
          r_bit_cnt <= '0;
          if (w_frame_ok) begin
            if (r_data == PS2_EXT) begin
              r_ext_pend <= 1'b1;
            end else if (r_data == PS2_BREAK) begin
              r_brk_pend <= 1'b1;
            end else if (r_brk_pend) begin
              // Release: keep the last make code visible, only drop the held flag.
              r_state    <= 1'b0;
              r_brk_pend <= 1'b0;
              r_ext_pend <= 1'b0;
            end else begin
              r_byte     <= r_data;
              r_ext      <= r_ext_pend;
              r_state    <= 1'b1;
              r_valid    <= 1'b1;
              r_ext_pend <= 1'b0;
            end
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
          // Data arrives LSB first, so shift in from the top.
          if (r_bit_cnt < PS2_PAR_IDX) r_data <= {w_data_s, r_data[7:1]};
`ifdef PS2_PARITY_CHECK_EN
          else r_par <= w_data_s;
`endif
        end
      end else if (r_bit_cnt != '0) begin
        // Stalled mid-frame: abort the partial frame but keep any pending prefix.
        if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          r_bit_cnt <= '0;
          r_to_cnt  <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign bus.ps2_byte   = r_byte;
  assign bus.ps2_state  = r_state;
  assign bus.ps2_ext    = r_ext;
  assign bus.byte_valid = r_valid;

endmodule

// File: tb/tb_ps2_rx_scanner.sv
module tb_ps2_rx_scanner;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   strobe_cnt = 0;
  int   snap;

  ps2_rx_scanner_if bus ();

  ps2_rx_scanner dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Counts every clk cycle with byte_valid high; a frame yielding a delta of
  // exactly one proves a single-cycle strobe.
  always @(posedge clk) if (bus.byte_valid === 1'b1) strobe_cnt <= strobe_cnt + 1;

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  // One PS/2 bit: data set while ps2_clk high, falling edge mid-bit.
  task automatic send_bit(input logic b);
    bus.ps2_data = b;
    wait_clks(10);
    bus.ps2_clk = 1'b0;
    wait_clks(10);
    bus.ps2_clk = 1'b1;
  endtask

  // Sends the first nbits of the frame for byte d with parity bit p.
  task automatic send_bits(input logic [7:0] d, input logic p, input int nbits);
    logic [10:0] f;
    f = {1'b1, p, d, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i]);
    bus.ps2_data = 1'b1;
    wait_clks(10);
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_bits(d, ~^d, 11);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    wait_clks(5);
    @(negedge clk);
    checks++; if (bus.ps2_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h want 00", bus.ps2_byte); end
    checks++; if (bus.ps2_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b want 0", bus.ps2_state); end
    checks++; if (bus.ps2_ext !== 1'b0) begin errors++; $display("FAIL reset_ext: got %b want 0", bus.ps2_ext); end
    checks++; if (bus.byte_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.byte_valid); end
    rst_n = 1'b1;
    wait_clks(5);
  endtask

  task automatic test_make;
    snap = strobe_cnt;
    send_frame(8'h1C);
    @(negedge clk);
    checks++; if (bus.ps2_byte !== 8'h1C) begin errors++; $display("FAIL make_byte: got %h want 1c", bus.ps2_byte); end
    checks++; if (bus.ps2_state !== 1'b1) begin errors++; $display("FAIL make_state: got %b want 1", bus.ps2_state); end
    checks++; if (bus.ps2_ext !== 1'b0) begin errors++; $display("FAIL make_ext: got %b want 0", bus.ps2_ext); end
    checks++; if (strobe_cnt - snap !== 1) begin errors++; $display("FAIL make_strobe: got %0d want 1", strobe_cnt - snap); end
  endtask

  task automatic test_break;
    snap = strobe_cnt;
    send_frame(8'hF0);
    send_frame(8'h1C);
    @(negedge clk);
    checks++; if (strobe_cnt - snap !== 0) begin errors++; $display("FAIL break_strobe: got %0d want 0", strobe_cnt - snap); end
    checks++; if (bus.ps2_state !== 1'b0) begin errors++; $display("FAIL break_state: got %b want 0", bus.ps2_state); end
    checks++; if (bus.ps2_byte !== 8'h1C) begin errors++; $display("FAIL break_byte: got %h want 1c", bus.ps2_byte); end
  endtask

  task automatic test_extended;
    snap = strobe_cnt;
    send_frame(8'hE0);
    send_frame(8'h75);
    @(negedge clk);
    checks++; if (bus.ps2_byte !== 8'h75) begin errors++; $display("FAIL ext_byte: got %h want 75", bus.ps2_byte); end
    checks++; if (bus.ps2_ext !== 1'b1) begin errors++; $display("FAIL ext_flag: got %b want 1", bus.ps2_ext); end
    checks++; if (strobe_cnt - snap !== 1) begin errors++; $display("FAIL ext_strobe: got %0d want 1", strobe_cnt - snap); end
    snap = strobe_cnt;
    send_frame(8'h16);
    @(negedge clk);
    checks++; if (bus.ps2_byte !== 8'h16) begin errors++; $display("FAIL plain_byte: got %h want 16", bus.ps2_byte); end
    checks++; if (bus.ps2_ext !== 1'b0) begin errors++; $display("FAIL plain_ext: got %b want 0", bus.ps2_ext); end
    checks++; if (strobe_cnt - snap !== 1) begin errors++; $display("FAIL plain_strobe: got %0d want 1", strobe_cnt - snap); end
  endtask

  task automatic test_parity;
    snap = strobe_cnt;
    send_bits(8'h1C, 1'b1, 11);   // correct parity for 1C is 0
    @(negedge clk);
`ifdef PS2_PARITY_CHECK_EN
    checks++; if (bus.ps2_byte !== 8'h16) begin errors++; $display("FAIL parity_byte: got %h want 16", bus.ps2_byte); end
    checks++; if (strobe_cnt - snap !== 0) begin errors++; $display("FAIL parity_strobe: got %0d want 0", strobe_cnt - snap); end
`else
    checks++; if (bus.ps2_byte !== 8'h1C) begin errors++; $display("FAIL parity_byte: got %h want 1c", bus.ps2_byte); end
    checks++; if (strobe_cnt - snap !== 1) begin errors++; $display("FAIL parity_strobe: got %0d want 1", strobe_cnt - snap); end
`endif
  endtask

  task automatic test_back_to_back;
    snap = strobe_cnt;
    send_frame(8'h1C);
    send_frame(8'h1C);
    @(negedge clk);
    checks++; if (strobe_cnt - snap !== 2) begin errors++; $display("FAIL repeat_strobe: got %0d want 2", strobe_cnt - snap); end
    checks++; if (bus.ps2_byte !== 8'h1C) begin errors++; $display("FAIL repeat_byte: got %h want 1c", bus.ps2_byte); end
    checks++; if (bus.ps2_state !== 1'b1) begin errors++; $display("FAIL repeat_state: got %b want 1", bus.ps2_state); end
  endtask

  task automatic test_start_glitch;
    snap = strobe_cnt;
    send_bit(1'b1);               // high "start" bit must be ignored
    send_frame(8'h5A);
    @(negedge clk);
    checks++; if (bus.ps2_byte !== 8'h5A) begin errors++; $display("FAIL glitch_byte: got %h want 5a", bus.ps2_byte); end
    checks++; if (strobe_cnt - snap !== 1) begin errors++; $display("FAIL glitch_strobe: got %0d want 1", strobe_cnt - snap); end
  endtask

  task automatic test_timeout;
    snap = strobe_cnt;
    send_bits(8'h33, 1'b1, 5);
    wait_clks(60000);
    send_frame(8'h45);
    @(negedge clk);
    checks++; if (bus.ps2_byte !== 8'h45) begin errors++; $display("FAIL timeout_byte: got %h want 45", bus.ps2_byte); end
    checks++; if (strobe_cnt - snap !== 1) begin errors++; $display("FAIL timeout_strobe: got %0d want 1", strobe_cnt - snap); end
  endtask

  task automatic test_reset_mid_frame;
    send_bits(8'h66, 1'b1, 4);
    rst_n = 1'b0;
    wait_clks(3);
    @(negedge clk);
    checks++; if (bus.ps2_byte !== 8'h00) begin errors++; $display("FAIL rstmid_byte: got %h want 00", bus.ps2_byte); end
    checks++; if (bus.ps2_state !== 1'b0) begin errors++; $display("FAIL rstmid_state: got %b want 0", bus.ps2_state); end
    checks++; if (bus.ps2_ext !== 1'b0) begin errors++; $display("FAIL rstmid_ext: got %b want 0", bus.ps2_ext); end
    checks++; if (bus.byte_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", bus.byte_valid); end
    rst_n = 1'b1;
    wait_clks(5);
    snap = strobe_cnt;
    send_frame(8'h29);
    @(negedge clk);
    checks++; if (bus.ps2_byte !== 8'h29) begin errors++; $display("FAIL rstmid_after_byte: got %h want 29", bus.ps2_byte); end
    checks++; if (bus.ps2_state !== 1'b1) begin errors++; $display("FAIL rstmid_after_state: got %b want 1", bus.ps2_state); end
    checks++; if (strobe_cnt - snap !== 1) begin errors++; $display("FAIL rstmid_after_strobe: got %0d want 1", strobe_cnt - snap); end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    test_reset();
    test_make();
    test_break();
    test_extended();
    test_parity();
    test_back_to_back();
    test_start_glitch();
    test_timeout();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
